// File: rtl/rv32_regfile_pkg.sv
// rv32_regfile_pkg: shared FSM states, PC step and flat bank addressing for the multi-hart regfile.
package rv32_regfile_pkg;
   typedef enum logic {CLEAR, RUN} state_e;
   localparam int PC_INC = 4;
   function automatic logic [31:0] flat_addr(input logic [31:0] hart, input logic [31:0] idx,
                                             input int log2_harts, input int log2_entries);
      return ((hart & ((32'd1 << log2_harts) - 32'd1)) << log2_entries) |
             (idx & ((32'd1 << log2_entries) - 32'd1));
   endfunction
endpackage

// File: rtl/rv32_regfile_bank.sv
// rv32_regfile_bank: 2-read/1-write synchronous array, read-before-write.
// A third read port exists only when RV32_REGFILE_DBG_EN is defined.
module rv32_regfile_bank #(
   parameter int XLEN = 32,
   parameter int AW = 5
) (
   input  logic            clk,
   input  logic            we,
   input  logic [AW-1:0]   waddr,
   input  logic [XLEN-1:0] wdata,
   input  logic [AW-1:0]   ra1,
   input  logic [AW-1:0]   ra2,
   output logic [XLEN-1:0] rd1,
   output logic [XLEN-1:0] rd2
`ifdef RV32_REGFILE_DBG_EN
   ,
   input  logic [AW-1:0]   ra3,
   output logic [XLEN-1:0] rd3
`endif
);
   logic [XLEN-1:0] mem [1<<AW];
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      rd1 <= mem[ra1];
      rd2 <= mem[ra2];
`ifdef RV32_REGFILE_DBG_EN
      rd3 <= mem[ra3];
`endif
   end
endmodule

// File: rtl/rv32_regfile_mt.sv
// rv32_regfile_mt: multi-hart integer register file with per-hart PCs, clear sequencer and forwarding.
// Define RV32_REGFILE_DBG_EN to add the debugger access port.
module rv32_regfile_mt
   import rv32_regfile_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int LOG2_ENTRIES = 5,
   parameter int LOG2_HARTS = 0,
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
   localparam int HW = (LOG2_HARTS < 1) ? 1 : LOG2_HARTS
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic [HW-1:0]           rd_hart,
   input  logic [LOG2_ENTRIES-1:0] rs1_idx,
   input  logic [LOG2_ENTRIES-1:0] rs2_idx,
   input  logic [HW-1:0]           wr_hart,
   input  logic [LOG2_ENTRIES-1:0] rd_idx,
   input  logic                    rd_we,
   input  logic [XLEN-1:0]         new_rd,
   input  logic [XLEN-1:0]         new_pc,
   input  logic                    update_pc,
   input  logic                    stall,
   output logic [XLEN-1:0]         rs1,
   output logic [XLEN-1:0]         rs2,
   output logic [XLEN-1:0]         pc,
   output logic [XLEN-1:0]         last_pc,
   output logic                    ready
`ifdef RV32_REGFILE_DBG_EN
   ,
   input  logic                    dbg_req,
   input  logic                    dbg_wr,
   input  logic [HW-1:0]           dbg_hart,
   input  logic [LOG2_ENTRIES-1:0] dbg_idx,
   input  logic [XLEN-1:0]         dbg_wdata,
   output logic [XLEN-1:0]         dbg_rdata,
   output logic                    dbg_ack
`endif
);
   localparam int AW = LOG2_HARTS + LOG2_ENTRIES;
   localparam logic [XLEN-1:0] INC = XLEN'(PC_INC);

   state_e state, state_n;
   logic [AW-1:0] clr_cnt, clr_n, a1_n, a2_n, a1_q, a2_q, uw_addr, w_addr, wq_addr, d_addr;
   logic [HW-1:0] rh, rh_q, rh_n;
   logic [LOG2_ENTRIES-1:0] i1_q, i2_q, i1_n, i2_n;
   logic [XLEN-1:0] w_data, wq_data, d_wdata, b1, b2;
   logic [XLEN-1:0] pcs [1<<HW];
   logic clearing, adv, user_we, dbg_we, w_en, wq_en;

   assign clearing = state == CLEAR;
   assign ready = state == RUN;
   assign adv = ready && !stall;
   assign user_we = adv && rd_we && rd_idx != '0;
   assign rh = (LOG2_HARTS == 0) ? '0 : rd_hart;
   assign rh_n = stall ? rh_q : rd_hart;
   assign i1_n = stall ? i1_q : rs1_idx;
   assign i2_n = stall ? i2_q : rs2_idx;
   assign a1_n = AW'(flat_addr(32'(rh_n), 32'(i1_n), LOG2_HARTS, LOG2_ENTRIES));
   assign a2_n = AW'(flat_addr(32'(rh_n), 32'(i2_n), LOG2_HARTS, LOG2_ENTRIES));
   assign a1_q = AW'(flat_addr(32'(rh_q), 32'(i1_q), LOG2_HARTS, LOG2_ENTRIES));
   assign a2_q = AW'(flat_addr(32'(rh_q), 32'(i2_q), LOG2_HARTS, LOG2_ENTRIES));
   assign uw_addr = AW'(flat_addr(32'(wr_hart), 32'(rd_idx), LOG2_HARTS, LOG2_ENTRIES));
   // Clear, user and debug writes are mutually exclusive by ready/stall
   assign w_en = clearing || user_we || dbg_we;
   assign w_addr = clearing ? clr_cnt : dbg_we ? d_addr : uw_addr;
   assign w_data = clearing ? '0 : dbg_we ? d_wdata : new_rd;

   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         state <= CLEAR;
         clr_cnt <= '0;
      end else begin
         state <= state_n;
         clr_cnt <= clr_n;
      end

   always_comb begin
      state_n = state;
      clr_n = clr_cnt;
      if (clearing) begin
         clr_n = clr_cnt + 1'b1;
         state_n = (clr_cnt == '1) ? RUN : CLEAR;
      end
   end

   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         rh_q <= '0;
         i1_q <= '0;
         i2_q <= '0;
         wq_en <= 1'b0;
         wq_addr <= '0;
         wq_data <= '0;
      end else begin
         rh_q <= rh_n;
         i1_q <= i1_n;
         i2_q <= i2_n;
         wq_en <= w_en;
         wq_addr <= w_addr;
         wq_data <= w_data;
      end

   function automatic logic [XLEN-1:0] fwd(input logic [AW-1:0] a, input logic zero,
                                           input logic [XLEN-1:0] arr);
      return (!ready || zero) ? '0 : (w_en && w_addr == a) ? w_data :
             (wq_en && wq_addr == a) ? wq_data : arr;
   endfunction

   assign rs1 = fwd(a1_q, i1_q == '0, b1);
   assign rs2 = fwd(a2_q, i2_q == '0, b2);
   assign pc = pcs[rh];

   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         for (int h = 0; h < (1 << HW); h++) pcs[h] <= XLEN'(RESET_VECTOR);
         last_pc <= '0;
      end else if (adv) begin
         last_pc <= pc - INC;
         pcs[rh] <= (update_pc ? new_pc : pc) + INC;
      end

`ifdef RV32_REGFILE_DBG_EN
   logic dbg_acc, dq_zero;
   logic [AW-1:0] dq_addr;
   logic [XLEN-1:0] b3;
   assign dbg_acc = dbg_req && stall && ready;
   assign dbg_we = dbg_acc && dbg_wr && dbg_idx != '0;
   assign d_addr = AW'(flat_addr(32'(dbg_hart), 32'(dbg_idx), LOG2_HARTS, LOG2_ENTRIES));
   assign d_wdata = dbg_wdata;
   assign dbg_rdata = fwd(dq_addr, dq_zero, b3);
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         dbg_ack <= 1'b0;
         dq_addr <= '0;
         dq_zero <= 1'b1;
      end else begin
         dbg_ack <= dbg_acc;
         dq_addr <= d_addr;
         dq_zero <= dbg_idx == '0;
      end
`else
   assign dbg_we = 1'b0;
   assign d_addr = '0;
   assign d_wdata = '0;
`endif

   rv32_regfile_bank #(.XLEN(XLEN), .AW(AW)) u_bank (
      .clk(clk), .we(w_en), .waddr(w_addr), .wdata(w_data),
      .ra1(a1_n), .ra2(a2_n), .rd1(b1), .rd2(b2)
`ifdef RV32_REGFILE_DBG_EN
      , .ra3(d_addr), .rd3(b3)
`endif
   );
endmodule

// File: tb/tb_rv32_regfile_mt.sv
// tb_rv32_regfile_mt: randomized check of the two-hart regfile against an architectural reference model.
module tb_rv32_regfile_mt;
   localparam int LE = 5;
   localparam int LH = 1;
   localparam int NH = 2;
   localparam int NE = NH * 32;
   localparam logic [31:0] RV = 32'h0000_0080;

   logic clk = 1'b0;
   logic reset_n = 1'b1;
   logic [0:0] rd_hart, wr_hart;
   logic [4:0] rs1_idx, rs2_idx, rd_idx;
   logic rd_we, update_pc, stall, ready;
   logic [31:0] new_rd, new_pc, rs1, rs2, pc, last_pc;

   int total = 0;
   int bad = 0;

   logic [31:0] m_reg [NH][32];
   logic [31:0] m_pc [NH];
   logic [31:0] m_last;
   int m_clr;
   logic [0:0] m_h;
   logic [4:0] m1, m2;

   always #5 clk = ~clk;

   rv32_regfile_mt #(.XLEN(32), .LOG2_ENTRIES(LE), .LOG2_HARTS(LH), .RESET_VECTOR(RV)) dut (
      .clk(clk), .reset_n(reset_n), .rd_hart(rd_hart), .rs1_idx(rs1_idx), .rs2_idx(rs2_idx),
      .wr_hart(wr_hart), .rd_idx(rd_idx), .rd_we(rd_we), .new_rd(new_rd), .new_pc(new_pc),
      .update_pc(update_pc), .stall(stall), .rs1(rs1), .rs2(rs2), .pc(pc), .last_pc(last_pc),
      .ready(ready)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Reads see every write already done plus one being presented right now
   function automatic logic [31:0] m_read(input logic [4:0] i);
      if (m_clr < NE || i == 5'd0) return 32'd0;
      if (!stall && rd_we && rd_idx != 5'd0 && wr_hart == m_h && rd_idx == i) return new_rd;
      return m_reg[m_h][i];
   endfunction

   task automatic step();
      #1;
      chk("ready", 32'(ready), 32'(m_clr >= NE));
      chk("rs1", rs1, m_read(m1));
      chk("rs2", rs2, m_read(m2));
      chk("pc", pc, m_pc[rd_hart]);
      chk("last_pc", last_pc, m_last);
      @(posedge clk);
      if (m_clr >= NE && !stall) begin
         if (rd_we && rd_idx != 5'd0) m_reg[wr_hart][rd_idx] = new_rd;
         m_last = m_pc[rd_hart] - 32'd4;
         m_pc[rd_hart] = (update_pc ? new_pc : m_pc[rd_hart]) + 32'd4;
      end
      if (!stall) begin
         m_h = rd_hart;
         m1 = rs1_idx;
         m2 = rs2_idx;
      end
      if (m_clr < NE) m_clr++;
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      #1;
      chk("rst_ready", 32'(ready), 32'd0);
      chk("rst_rs1", rs1, 32'd0);
      chk("rst_rs2", rs2, 32'd0);
      chk("rst_pc", pc, RV);
      chk("rst_last_pc", last_pc, 32'd0);
      foreach (m_reg[h, i]) m_reg[h][i] = 32'd0;
      foreach (m_pc[h]) m_pc[h] = RV;
      m_last = 32'd0;
      m_clr = 0;
      m_h = 1'b0;
      m1 = 5'd0;
      m2 = 5'd0;
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   function automatic logic [4:0] pick();
      return 5'(($urandom % 4 == 0) ? $urandom_range(0, 31) : $urandom_range(0, 7));
   endfunction

   task automatic rand_in();
      rd_hart = 1'($urandom_range(0, 1));
      wr_hart = 1'($urandom_range(0, 1));
      rs1_idx = pick();
      rs2_idx = pick();
      rd_idx = pick();
      rd_we = ($urandom % 10) < 6;
      update_pc = ($urandom % 5) == 0;
      stall = ($urandom % 4) == 0;
      new_rd = $urandom;
      new_pc = $urandom;
   endtask

   task automatic idle();
      rd_we = 1'b0;
      update_pc = 1'b0;
      stall = 1'b0;
   endtask

   initial begin
      {rd_hart, wr_hart, rs1_idx, rs2_idx, rd_idx, rd_we, update_pc, stall} = '0;
      new_rd = '0;
      new_pc = '0;
      @(negedge clk);
      do_reset();
      for (int c = 0; c < 10; c++) begin rand_in(); step(); end
      do_reset();
      for (int c = 0; c < NE + 4; c++) begin rand_in(); step(); end
      // per-hart storage and x0 immunity
      idle();
      rd_we = 1'b1; wr_hart = 1'b0; rd_idx = 5'd5; new_rd = 32'hA5A5_A5A5; step();
      wr_hart = 1'b1; new_rd = 32'h1234_5678; step();
      rd_idx = 5'd0; new_rd = 32'hFFFF_FFFF; step();
      idle();
      rd_hart = 1'b0; rs1_idx = 5'd5; rs2_idx = 5'd0; step();
      rd_hart = 1'b1; #1 chk("h0_x5", rs1, 32'hA5A5_A5A5); chk("x0", rs2, 32'd0); step();
      #1 chk("h1_x5", rs1, 32'h1234_5678); step();
      // back-to-back forwarding
      rd_hart = 1'b0; wr_hart = 1'b0; rs1_idx = 5'd3; rd_we = 1'b1; rd_idx = 5'd3; new_rd = 32'h11; step();
      rd_we = 1'b0; #1 chk("fwd_delayed", rs1, 32'h11); step();
      rd_we = 1'b1; new_rd = 32'h22; #1 chk("fwd_comb", rs1, 32'h22); step();
      // PC update, stall hold and release
      idle();
      update_pc = 1'b1; new_pc = 32'h100; step();
      update_pc = 1'b0; stall = 1'b1; #1 chk("pc_upd", pc, 32'h104); step();
      stall = 1'b0; #1 chk("pc_hold", pc, 32'h104); step();
      #1 chk("pc_adv", pc, 32'h108); chk("last_adv", last_pc, 32'h100); step();
      update_pc = 1'b1; new_pc = 32'hFFFF_FFFC; step();
      update_pc = 1'b0; #1 chk("pc_wrap", pc, 32'd0); step();
      for (int c = 0; c < 3000; c++) begin rand_in(); step(); end
      // reset mid-run wipes earlier writes
      idle();
      rd_we = 1'b1; wr_hart = 1'b1; rd_idx = 5'd9; new_rd = 32'hCAFE_F00D; step();
      idle();
      do_reset();
      while (m_clr < NE) begin rand_in(); step(); end
      idle(); rd_hart = 1'b1; rs1_idx = 5'd9; rs2_idx = 5'd5; step();
      #1 chk("post_rst_x9", rs1, 32'd0); chk("post_rst_x5", rs2, 32'd0); step();
      for (int c = 0; c < 500; c++) begin rand_in(); step(); end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
